// File: rtl/passcode_entry.sv
// Keypad passcode controller: collects BCD digits, checks them against a stored PIN,
// allows the PIN to be changed while open and locks out after repeated failures.
module passcode_entry #(
    parameter int                   PIN_LEN     = 4,
    parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN = 16'h1234,
    parameter int                   MAX_FAIL    = 3,
    parameter logic [31:0]          LOCK_CYCLES = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    output logic       unlocked,
    output logic       alarm,
    output logic       err_pulse,
    output logic [2:0] digit_count,
    output logic       set_mode
);

    localparam int             FW       = $clog2(MAX_FAIL + 1);
    localparam int             BW       = 4 * PIN_LEN;
    localparam logic [2:0]     FULL     = 3'(PIN_LEN);
    localparam logic [FW-1:0]  FAIL_LIM = FW'(MAX_FAIL);

    typedef enum logic [2:0] {ENTRY, CHECK, OPEN, SET, LOCKOUT} state_t;

    state_t         state_q, state_nxt;
    logic [BW-1:0]  buf_q, buf_nxt;
    logic [BW-1:0]  pin_q, pin_nxt;
    logic [2:0]     cnt_q, cnt_nxt;
    logic [FW-1:0]  fail_q, fail_nxt;
    logic [31:0]    lock_q, lock_nxt;
    logic           err_q, err_nxt;

    logic           is_digit, is_star, is_hash, buf_full, pin_match;
    logic [BW+3:0]  shift_wide;
    logic [BW-1:0]  buf_shifted;
    logic [FW-1:0]  fail_inc;

    assign is_digit    = key_valid && (key_value <= 4'd9);
    assign is_star     = key_valid && (key_value == 4'd14);
    assign is_hash     = key_valid && (key_value == 4'd15);
    assign buf_full    = (cnt_q == FULL);
    assign pin_match   = buf_full && (buf_q == pin_q);
    // Newest digit lands in the low nibble, so the first key ends up most significant.
    assign shift_wide  = {buf_q, key_value};
    assign buf_shifted = shift_wide[BW-1:0];
    assign fail_inc    = fail_q + FW'(1);

    always_comb begin
        state_nxt = state_q;
        buf_nxt   = buf_q;
        pin_nxt   = pin_q;
        cnt_nxt   = cnt_q;
        fail_nxt  = fail_q;
        lock_nxt  = lock_q;
        err_nxt   = 1'b0;
        case (state_q)
            ENTRY: begin
                if (is_digit) begin
                    if (!buf_full) begin
                        buf_nxt = buf_shifted;
                        cnt_nxt = cnt_q + 3'd1;
                    end
                end else if (is_star) begin
                    buf_nxt = '0;
                    cnt_nxt = '0;
                end else if (is_hash) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                buf_nxt = '0;
                cnt_nxt = '0;
                if (pin_match) begin
                    state_nxt = OPEN;
                    fail_nxt  = '0;
                end else begin
                    err_nxt  = 1'b1;
                    fail_nxt = fail_inc;
                    if (fail_inc == FAIL_LIM) begin
                        state_nxt = LOCKOUT;
                        lock_nxt  = LOCK_CYCLES - 32'd1;
                    end else begin
                        state_nxt = ENTRY;
                    end
                end
            end
            OPEN: begin
                if (is_hash) begin
                    state_nxt = ENTRY;
                end else if (is_star) begin
                    state_nxt = SET;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            SET: begin
                if (is_digit) begin
                    if (!buf_full) begin
                        buf_nxt = buf_shifted;
                        cnt_nxt = cnt_q + 3'd1;
                    end
                end else if (is_hash) begin
                    // A short new PIN is rejected rather than padded.
                    if (buf_full) pin_nxt = buf_q;
                    else          err_nxt = 1'b1;
                    state_nxt = OPEN;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (is_star) begin
                    state_nxt = OPEN;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            LOCKOUT: begin
                if (lock_q == 32'd0) begin
                    state_nxt = ENTRY;
                    fail_nxt  = '0;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    lock_nxt = lock_q - 32'd1;
                end
            end
            default: state_nxt = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            buf_q   <= '0;
            pin_q   <= DEFAULT_PIN;
            cnt_q   <= '0;
            fail_q  <= '0;
            lock_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            buf_q   <= buf_nxt;
            pin_q   <= pin_nxt;
            cnt_q   <= cnt_nxt;
            fail_q  <= fail_nxt;
            lock_q  <= lock_nxt;
            err_q   <= err_nxt;
        end
    end

    assign unlocked    = (state_q == OPEN) || (state_q == SET);
    assign alarm       = (state_q == LOCKOUT);
    assign set_mode    = (state_q == SET);
    assign err_pulse   = err_q;
    assign digit_count = cnt_q;

endmodule
